mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
- Sequential unsigned 32x32 -> 64 shift-add multiplier with a valid/ready handshake on both sides.
- Sits directly upstream of, and wraps, adder32: it drives adder32's a/b/cin every cycle and consumes its sum/cout to build the partial product.
- Retires one multiplier bit per clock.
- Serves as the team's multi-cycle arithmetic stage ahead of the accumulate path.

Parameters:
- WIDTH, 32, operand width. Only 32 is legal because it matches adder32. An elaboration-time assertion fires for any other value.
- EARLY_OUT, 1, when 1 an accepted operand pair with either operand zero completes in one step with product 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- mcand  input  WIDTH  multiplicand
- mplier  input  WIDTH  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  unsigned product
- busy  output  1  high while in RUN

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low; it is fixed by the team.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, busy=0, product=0, all internal registers 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch mcand into M, load P_hi=0, P_lo=mplier, cnt=0, then go to RUN.
    - If EARLY_OUT=1 and (mcand==0 or mplier==0), go straight to DONE with product=0.
  - RUN: busy=1, in_ready=0. Each edge performs one step:
    - adder32 a=P_hi, b=(P_lo[0] ? M : 0), cin=0.
    - {P_hi,P_lo} <= {cout, sum, P_lo[31:1]} >> 0 taken as 65->64 shift: P_hi={cout,sum[31:1]}, P_lo={sum[0],P_lo[31:1]}.
    - cnt increments. When cnt==31 on an edge, go to DONE.
  - DONE: out_valid=1, product={P_hi,P_lo}, held stable until out_ready. On out_valid&&out_ready, go to IDLE and clear out_valid.
- Latency:
  - If the accept edge is edge 0, out_valid is high after edge 32 (33 cycles accept-to-valid including the accept cycle).
  - An early-out result is valid after edge 0.
- Throughput: at most one operation in flight. in_ready=0 in RUN and DONE; a new accept is possible the cycle after the DONE handshake.
- Arithmetic:
  - The adder carry (cout) must feed P_hi bit 31. Dropping it is a bug that shows up for 0xFFFFFFFF operands.
  - The product is exact modulo 2^64; overflow is impossible.
- Boundary conditions:
  - in_valid during RUN/DONE is ignored; operands are not sampled.
  - out_ready high before out_valid has no effect.
  - Operand changes after the accept edge have no effect.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately, with no product and no out_valid.
- Invariants: out_valid and in_ready are never both 1; busy==(state==RUN).

Decomposition:
- Shared package (arith_pkg):
  - state enum {IDLE, RUN, DONE}
  - localparam WIDTH_C=32
  - localparam CNT_W=$clog2(WIDTH_C)
  - localparam PROD_W=2*WIDTH_C
- Sub-module: one adder32 instance, used unchanged, with cin tied to 0.

Test Plan:
- 3 x 5 accepted, out_ready=1 -> out_valid exactly 32 edges after the accept edge; product=0x000000000000000F; in_ready low throughout.
- 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001. Checks cout propagation.
- EARLY_OUT=1, 0 x 0x12345678 -> out_valid one edge after accept, product=0. EARLY_OUT=0 -> product 0 after 32 edges.
- 0x10000 x 0x10000 with out_ready held 0 for 10 cycles after out_valid:
  - product=0x0000000100000000 is stable the whole time.
  - in_valid pulses are ignored.
  - After out_ready, the next accept happens one cycle later.
- rst_n pulsed low at step 15 of 0xDEADBEEF x 0x2 -> all outputs 0 asynchronously. A following 7 x 6 yields 42 with no stale data.
- Random: 500 pairs with random in_valid/out_ready gaps -> every product equals the 64-bit reference. Accept and retire counts are equal.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and constants for the multi-cycle arithmetic stage.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_C = 32;
  localparam int CNT_W   = $clog2(WIDTH_C);
  localparam int PROD_W  = 2 * WIDTH_C;

  function automatic logic is_zero(input logic [WIDTH_C-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-style adder with carry in/out, used as the multiplier's step adder.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier, one multiplier bit per clock,
// with valid/ready handshakes on operand and product sides.
module mult32_seq
  import arith_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  generate
    if (WIDTH != WIDTH_C) begin : g_bad_width
      $error("mult32_seq: WIDTH must be 32 to match adder32");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m, p_hi, p_lo;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             accept, early, last_step;
  logic [WIDTH-1:0] add_b, sum;
  logic             cout;

  assign add_b = p_lo[0] ? m : '0;

  adder32 u_add (
    .a   (p_hi),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  // armed holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    early     = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        in_ready = armed;
        accept   = in_valid && armed;
        early    = EARLY_OUT && (is_zero(mcand) || is_zero(mplier));
        if (accept) state_nxt = early ? DONE : RUN;
      end
      RUN: begin
        busy      = 1'b1;
        last_step = (cnt == CNT_W'(WIDTH - 1));
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The adder carry becomes the new top bit of P_hi; the whole 65-bit value shifts right by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      cnt  <= '0;
    end else if (accept) begin
      m    <= mcand;
      p_hi <= '0;
      p_lo <= early ? '0 : mplier;
      cnt  <= '0;
    end else if (busy) begin
      p_hi <= {cout, sum[WIDTH-1:1]};
      p_lo <= {sum[0], p_lo[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
    end
  end

  assign product = {p_hi, p_lo};

endmodule

// File: tb/tb_mult32_seq.sv
// Directed and randomized bench for mult32_seq with a product scoreboard.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] mcand, mplier;
  logic [63:0] product;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [31:0] mcand0, mplier0;
  logic [63:0] product0;

  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  int          n_ret = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  mult32_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mcand(mcand), .mplier(mplier),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mult32_seq #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .mcand(mcand0), .mplier(mplier0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .product(product0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record handshakes that the coming edge will complete, then advance to the next negedge.
  task automatic tick();
    logic [63:0] e;
    if (in_valid && in_ready) begin
      sb.push_back(64'(mcand) * 64'(mplier));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_ret++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty got=%h exp=none", product);
      end else begin
        e = sb.pop_front();
        chk("sb_product", product, e);
      end
    end
    chk("inv_ready_valid", 64'(out_valid && in_ready), 64'(0));
    @(negedge clk);
  endtask

  task automatic do_op(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                       input logic [63:0] expp, input int explat);
    int n;
    logic ir;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; mcand = mc; mplier = mp; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; mcand = ~mc; mplier = ~mp;
    n = 0; ir = 1'b0;
    while (!out_valid && n < 100) begin
      ir = ir | in_ready;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(explat));
    chk({tag, "_inready_low"}, 64'(ir), 64'(0));
    chk({tag, "_product"}, product, expp);
    tick();
    chk({tag, "_valid_clr"}, 64'(out_valid), 64'(0));
    chk({tag, "_reaccept"}, 64'(in_ready), 64'(1));
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    logic have;
    logic [31:0] rmc, rmp;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; mcand0 = '0; mplier0 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_product", product, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("rel_in_ready_post", 64'(in_ready), 64'(1));

    do_op("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32);
    do_op("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    do_op("early", 32'd0, 32'h1234_5678, 64'h0, 0);

    // EARLY_OUT=0 instance takes the full 32 steps for a zero operand
    in_valid0 = 1'b1; mcand0 = 32'd0; mplier0 = 32'h1234_5678; out_ready0 = 1'b1;
    chk("noearly_ready", 64'(in_ready0), 64'(1));
    @(negedge clk);
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 100) begin @(negedge clk); n++; end
    chk("noearly_latency", 64'(n), 64'(32));
    chk("noearly_product", product0, 64'h0);
    @(negedge clk);
    chk("noearly_valid_clr", 64'(out_valid0), 64'(0));

    // Product held while the consumer stalls; operand offers are ignored
    in_valid = 1'b1; mcand = 32'h1_0000; mplier = 32'h1_0000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("stall_latency", 64'(n), 64'(32));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; mcand = 32'd9; mplier = 32'd9;
      chk("stall_product", product, 64'h0000_0001_0000_0000);
      chk("stall_valid", 64'(out_valid), 64'(1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("stall_reaccept", 64'(in_ready), 64'(1));
    chk("stall_queue_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset in the middle of a run
    in_valid = 1'b1; mcand = 32'hDEAD_BEEF; mplier = 32'h2;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("mid_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_product", product, 64'h0);
    sb.delete();
    n_acc = 0; n_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 32'd7, 32'd6, 64'd42, 32);

    // Randomized traffic against the scoreboard
    n_acc = 0; n_ret = 0; cyc = 0; have = 1'b0; rmc = '0; rmp = '0;
    while ((n_acc < 500 || n_ret < n_acc) && cyc < 60000) begin
      if (n_acc < 500) begin
        if (!have) begin rmc = rnd_op(); rmp = rnd_op(); have = 1'b1; end
        in_valid = ($urandom_range(0, 3) != 0);
        mcand = rmc; mplier = rmp;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) have = 1'b0;
      tick();
      cyc++;
    end
    chk("rand_in_time", 64'(cyc < 60000), 64'(1));
    chk("rand_accepts", 64'(n_acc), 64'(500));
    chk("rand_acc_eq_ret", 64'(n_ret), 64'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
